// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-key FSM states,
// 100 MHz default timing constants and the counter-width helper.
package key_debouncer_pkg;

  localparam int DEFAULT_NUM_KEYS        = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;    // 10 ms at 100 MHz
  localparam int DEFAULT_HOLD_CYCLES     = 100_000_000;  // 1 s at 100 MHz

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } key_state_e;

  // Both per-key counters share one width, large enough to hold the hold threshold.
  function automatic int cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bundle between board pins and the debouncer: raw active-low keys in,
// debounced level, press/release strobes and hold flags out.
interface key_debouncer_if #(
  parameter int NUM_KEYS = key_debouncer_pkg::DEFAULT_NUM_KEYS
);

  logic [NUM_KEYS-1:0] key_i;
  logic [NUM_KEYS-1:0] key_o;
  logic [NUM_KEYS-1:0] press_o;
  logic [NUM_KEYS-1:0] release_o;
  logic [NUM_KEYS-1:0] hold_o;

  modport master (
    output key_i,
    input  key_o,
    input  press_o,
    input  release_o,
    input  hold_o
  );

  modport slave (
    input  key_i,
    output key_o,
    output press_o,
    output release_o,
    output hold_o
  );

endinterface

// File: rtl/key_debouncer_cell.sv
// One key: 2-flop synchroniser, stability-window FSM, long-press timer and
// four registered outputs (level, press strobe, release strobe, hold flag).
module key_debouncer_cell
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_flag
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);

  // The sample that opens a window already counts as the first stable one,
  // so the window closes when the counter reaches DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic             key_s;
  key_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             key_reg;
  logic             press_reg;
  logic             release_reg;
  logic             hold_reg;

  assign key_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= 2'b11;
      state_reg    <= ST_RELEASED;
      cnt_reg      <= '0;
      hold_cnt_reg <= '0;
      key_reg      <= 1'b1;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], key_raw};
      press_reg   <= 1'b0;
      release_reg <= 1'b0;

      case (state_reg)
        ST_RELEASED: begin
          if (!key_s) begin
            state_reg <= ST_PRESS_CHK;
            cnt_reg   <= '0;
          end
        end

        ST_PRESS_CHK: begin
          if (key_s) begin
            state_reg <= ST_RELEASED;
          end else if (cnt_reg == DB_LAST) begin
            state_reg    <= ST_PRESSED;
            key_reg      <= 1'b0;
            press_reg    <= 1'b1;
            hold_cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_PRESSED: begin
          if (key_s) begin
            state_reg <= ST_RELEASE_CHK;
            cnt_reg   <= '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            // Counter parks at the threshold so a very long press never wraps.
            hold_reg <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
          end
        end

        ST_RELEASE_CHK: begin
          if (!key_s) begin
            state_reg <= ST_PRESSED;
          end else if (cnt_reg == DB_LAST) begin
            state_reg   <= ST_RELEASED;
            key_reg     <= 1'b1;
            release_reg <= 1'b1;
            hold_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: state_reg <= ST_RELEASED;
      endcase
    end
  end

  assign key_level     = key_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign hold_flag     = hold_reg;

endmodule

// File: rtl/key_debouncer.sv
// Debouncer for a bank of raw active-low push buttons; one independent
// cell per key, all outputs registered inside the cells.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic           clk100_i,
  input  logic           rstn_i,
  key_debouncer_if.slave keys
);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] hold_flag;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debouncer_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_cell (
      .clk           (clk100_i),
      .rst_n         (rstn_i),
      .key_raw       (keys.key_i[gi]),
      .key_level     (key_level[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .hold_flag     (hold_flag[gi])
    );
  end

  assign keys.key_o     = key_level;
  assign keys.press_o   = press_pulse;
  assign keys.release_o = release_pulse;
  assign keys.hold_o    = hold_flag;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a run-length reference model predicts
// strobe/hold events into a queue, a negedge monitor pops and compares them.
module tb_key_debouncer;

  localparam int NK   = 2;
  localparam int DB   = 8;
  localparam int HOLD = 40;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_HOLD    = 2;

  typedef struct {
    int cyc;
    int key;
    int kind;
  } ev_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  key_debouncer_if #(.NUM_KEYS(NK)) kif ();

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk100_i (clk),
    .rstn_i   (rstn),
    .keys     (kif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ev_t exp_q[$];

  // Reference model state: expected level/hold, two-sample pin delay,
  // length of the current run of samples disagreeing with the level,
  // and qualifying pressed samples since the press.
  logic [NK-1:0] lvl_exp;
  logic [NK-1:0] hold_exp;
  logic [NK-1:0] h1;
  logic [NK-1:0] h2;
  int            run_len [NK];
  int            ticks   [NK];
  logic [NK-1:0] hold_prev;

  function automatic string kind_name(input int kind);
    case (kind)
      EV_PRESS:   return "press";
      EV_RELEASE: return "release";
      default:    return "hold";
    endcase
  endfunction

  task automatic model_reset();
    lvl_exp  = '1;
    hold_exp = '0;
    h1       = '1;
    h2       = '1;
    for (int i = 0; i < NK; i++) begin
      run_len[i] = 0;
      ticks[i]   = 0;
    end
    exp_q.delete();
  endtask

  task automatic push_ev(input int k, input int kind);
    ev_t e;
    e.cyc  = cyc;
    e.key  = k;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Reference model, evaluated on each rising edge.
  initial begin
    logic ks;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        model_reset();
      end else begin
        for (int k = 0; k < NK; k++) begin
          ks    = h2[k];
          h2[k] = h1[k];
          h1[k] = kif.key_i[k];
          if (ks != lvl_exp[k]) begin
            run_len[k]++;
            if (run_len[k] == DB) begin
              lvl_exp[k] = ks;
              run_len[k] = 0;
              ticks[k]   = 0;
              if (ks) begin
                hold_exp[k] = 1'b0;
                push_ev(k, EV_RELEASE);
              end else begin
                push_ev(k, EV_PRESS);
              end
            end
          end else begin
            if (!lvl_exp[k] && run_len[k] == 0 && ticks[k] < HOLD) begin
              ticks[k]++;
              if (ticks[k] == HOLD) begin
                hold_exp[k] = 1'b1;
                push_ev(k, EV_HOLD);
              end
            end
            run_len[k] = 0;
          end
        end
      end
    end
  end

  // Asynchronous reset wipes the model and cancels any event of this cycle.
  initial begin
    forever begin
      @(negedge rstn);
      model_reset();
    end
  end

  task automatic take_event(input int k, input int kind);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s key %0d at cyc %0d, required no event",
               kind_name(kind), k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.key != k || e.kind != kind) begin
        n_fail++;
        $display("FAIL event_order: got %s key %0d cyc %0d, required %s key %0d cyc %0d",
                 kind_name(kind), k, cyc, kind_name(e.kind), e.key, e.cyc);
      end else begin
        $display("[TB] cyc %0d key %0d %s", cyc, k, kind_name(kind));
      end
    end
  endtask

  // Monitor: levels every cycle, events popped whenever the DUT shows one.
  initial begin
    ev_t e;
    hold_prev = '0;
    forever begin
      @(negedge clk);
      n_tests++;
      if (kif.key_o !== lvl_exp) begin
        n_fail++;
        $display("FAIL key_level cyc %0d: got %b, required %b", cyc, kif.key_o, lvl_exp);
      end
      n_tests++;
      if (kif.hold_o !== hold_exp) begin
        n_fail++;
        $display("FAIL hold_level cyc %0d: got %b, required %b", cyc, kif.hold_o, hold_exp);
      end
      for (int k = 0; k < NK; k++) begin
        if (kif.press_o[k] === 1'b1)   take_event(k, EV_PRESS);
        if (kif.release_o[k] === 1'b1) take_event(k, EV_RELEASE);
        if (kif.hold_o[k] === 1'b1 && hold_prev[k] === 1'b0) take_event(k, EV_HOLD);
      end
      hold_prev = kif.hold_o;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: got nothing at cyc %0d, required %s key %0d",
                 cyc, kind_name(e.kind), e.key);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_o"},     32'(kif.key_o),     32'h3);
    check({tag, "_press_o"},   32'(kif.press_o),   32'h0);
    check({tag, "_release_o"}, 32'(kif.release_o), 32'h0);
    check({tag, "_hold_o"},    32'(kif.hold_o),    32'h0);
  endtask

  initial begin
    int            seg_left [NK];
    logic [NK-1:0] seg_val;
    logic [NK-1:0] drive;

    kif.key_i = '1;
    rstn      = 1'b0;
    tick(3);
    check_reset_values("reset");
    rstn = 1'b1;

    // Idle keys: nothing must happen.
    tick(100);
    check("idle_key_o", 32'(kif.key_o), 32'h3);

    // Clean press: strobe exactly at +10.
    kif.key_i[0] = 1'b0;
    tick(9);
    check("press_early", 32'(kif.press_o[0]), 32'h0);
    tick(1);
    check("press_strobe", 32'(kif.press_o[0]), 32'h1);
    check("press_level",  32'(kif.key_o[0]),   32'h0);
    tick(1);
    check("press_one_cycle", 32'(kif.press_o[0]), 32'h0);
    tick(10);

    // Bounce while pressed, then release, then bounce while released.
    for (int i = 0; i < 10; i++) begin
      kif.key_i[0] = ~kif.key_i[0];
      tick(3);
    end
    kif.key_i[0] = 1'b0;
    tick(20);
    check("bounce_pressed_level", 32'(kif.key_o[0]), 32'h0);
    kif.key_i[0] = 1'b1;
    tick(20);
    check("release_level", 32'(kif.key_o[0]), 32'h1);
    for (int i = 0; i < 10; i++) begin
      kif.key_i[0] = ~kif.key_i[0];
      tick(3);
    end
    kif.key_i[0] = 1'b1;
    tick(20);
    check("bounce_released_level", 32'(kif.key_o[0]), 32'h1);

    // Long press on key 1.
    kif.key_i[1] = 1'b0;
    tick(10);
    check("hold_press", 32'(kif.press_o[1]), 32'h1);
    tick(39);
    check("hold_not_yet", 32'(kif.hold_o[1]), 32'h0);
    tick(1);
    check("hold_set", 32'(kif.hold_o[1]), 32'h1);
    tick(10);
    kif.key_i[1] = 1'b1;
    tick(10);
    check("hold_release_strobe", 32'(kif.release_o[1]), 32'h1);
    check("hold_cleared",        32'(kif.hold_o[1]),    32'h0);
    tick(20);

    // Simultaneous press on both keys.
    kif.key_i = 2'b00;
    tick(10);
    check("both_press", 32'(kif.press_o), 32'h3);
    tick(10);
    kif.key_i = 2'b11;
    tick(10);
    check("both_release", 32'(kif.release_o), 32'h3);
    tick(10);

    // Reset four cycles into the press window, key kept down.
    kif.key_i[0] = 1'b0;
    tick(7);
    rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    tick(3);
    rstn = 1'b1;
    tick(9);
    check("post_reset_early", 32'(kif.press_o[0]), 32'h0);
    tick(1);
    check("post_reset_press", 32'(kif.press_o[0]), 32'h1);
    kif.key_i[0] = 1'b1;
    tick(20);

    // Randomised segments with single-cycle glitches and rare resets.
    seg_val = '1;
    for (int k = 0; k < NK; k++) seg_left[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (seg_left[k] == 0) begin
          seg_val[k]  = ~seg_val[k];
          seg_left[k] = int'($urandom_range(90, 4));
        end
        seg_left[k]--;
        drive[k] = seg_val[k];
        if ($urandom_range(15, 0) == 0) drive[k] = ~drive[k];
      end
      kif.key_i = drive;
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(599, 0) == 0) rstn = 1'b0;
      tick(1);
    end

    kif.key_i = '1;
    rstn      = 1'b1;
    tick(40);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
